col2img16_packer: RTL and testbench

// - Write-side counterpart of the img2col16 BRAM reader. Accepts 16-lane x 8-bit result vectors

---
 rtl/col2img_pkg.sv | 17 +
 rtl/col2img16_packer_lane_compact16.sv | 25 ++
 rtl/col2img16_packer.sv | 127 ++++++++++++
 tb/tb_col2img16_packer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/col2img_pkg.sv
// Shared types and sizing helpers for the col2img16 write-side packer.
package col2img_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    localparam int LANES = 16;

    function automatic int buf_bytes(input int w);
        return 2 * w + LANES;
    endfunction

endpackage

// File: rtl/col2img16_packer_lane_compact16.sv
// Keeps the first N lanes of a 16-lane vector, zeroes the rest.
// Optional PACKER_RELU_EN clamps negative int8 lanes to zero.
module lane_compact16
    import col2img_pkg::*;
(
    input  logic [LANES*8-1:0] data_in,
    input  logic [4:0]         lane_num,
    output logic [LANES*8-1:0] data_out
);

    always_comb begin
        data_out = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_num == 5'd0 || i < int'(lane_num)) begin
`ifdef PACKER_RELU_EN
                data_out[i*8 +: 8] = data_in[i*8+7] ? 8'h00
                                                    : data_in[i*8 +: 8];
`else
                data_out[i*8 +: 8] = data_in[i*8 +: 8];
`endif
            end
        end
    end

endmodule

// File: rtl/col2img16_packer.sv
// Packs N-lane result vectors into BRAM words with a trailing byte-enabled word.
// Macro PACKER_RELU_EN (in lane_compact16) zeroes negative bytes before packing.
module col2img16_packer
    import col2img_pkg::*;
#(
    parameter int DATA_OUT_WIDTH = 8,
    parameter int DEPTH          = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        start,
    input  logic [31:0]                 output_offset,
    input  logic [4:0]                  lane_num,
    input  logic [LANES*8-1:0]          data_in,
    input  logic                        data_vld_in,
    input  logic                        data_last_in,
    output logic                        in_rdy,
    output logic [DATA_OUT_WIDTH*8-1:0] wr_data,
    output logic [DATA_OUT_WIDTH-1:0]   wr_be,
    output logic [$clog2(DEPTH)-1:0]    wr_addr,
    output logic                        wr_en,
    output logic                        done
);

    localparam int W  = DATA_OUT_WIDTH;
    localparam int BB = buf_bytes(W);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(BB + 1);

    state_t            state_q, state_d;
    logic [BB*8-1:0]   buf_q, buf_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [FW-1:0]     pos;
    logic [FW-1:0]     n_lanes;
    logic [4:0]        lane_q;
    logic [LANES*8-1:0] lanes;
    logic              drain, partial, accept;
    logic [W-1:0]      be_d;
    logic [W*8-1:0]    data_d;

    lane_compact16 u_compact (
        .data_in  (data_in),
        .lane_num (lane_q),
        .data_out (lanes)
    );

    assign n_lanes = (lane_q == 5'd0 || lane_q > 5'd16) ? FW'(LANES)
                                                         : FW'(lane_q);
    assign in_rdy  = (state_q == RUN) && (fill_q <= FW'(BB - LANES));
    assign accept  = data_vld_in && in_rdy;
    assign drain   = (state_q == RUN || state_q == FLUSH)
                  && (fill_q >= FW'(W));
    assign partial = (state_q == FLUSH) && (fill_q != '0)
                  && (fill_q < FW'(W));
    assign done    = (state_q == DONE);

    always_comb begin
        be_d   = '0;
        data_d = '0;
        if (drain)
            be_d = '1;
        else if (partial)
            be_d = W'((32'd1 << fill_q) - 32'd1);
        for (int b = 0; b < W; b++)
            data_d[b*8 +: 8] = be_d[b] ? buf_q[b*8 +: 8] : 8'h00;
    end

    // New bytes land behind whatever survives this cycle's drain.
    always_comb begin
        buf_d  = buf_q;
        fill_d = fill_q;
        pos    = fill_q;
        if (drain) begin
            buf_d  = buf_q >> (W * 8);
            fill_d = fill_q - FW'(W);
            pos    = fill_q - FW'(W);
        end
        if (partial) begin
            buf_d  = '0;
            fill_d = '0;
        end
        if (accept) begin
            buf_d  = buf_d | ({{((BB - LANES) * 8){1'b0}}, lanes}
                              << {pos, 3'b000});
            fill_d = fill_d + n_lanes;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && data_last_in) state_d = FLUSH;
            FLUSH:   if (fill_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q <= IDLE;
            buf_q   <= '0;
            fill_q  <= '0;
            lane_q  <= '0;
            wr_en   <= 1'b0;
            wr_be   <= '0;
            wr_data <= '0;
            wr_addr <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            wr_en   <= drain || partial;
            wr_be   <= be_d;
            wr_data <= data_d;
            if (state_q == IDLE && start) begin
                wr_addr <= output_offset[AW-1:0];
                lane_q  <= lane_num;
            end else if (wr_en) begin
                wr_addr <= wr_addr + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_col2img16_packer.sv
// Directed bench for col2img16_packer at W=8, DEPTH=1024.
module tb_col2img16_packer;

    logic         clk = 1'b0;
    logic         rst, clr, start;
    logic [31:0]  output_offset;
    logic [4:0]   lane_num;
    logic [127:0] data_in;
    logic         data_vld_in, data_last_in;
    logic         in_rdy, wr_en, done;
    logic [63:0]  wr_data;
    logic [7:0]   wr_be;
    logic [9:0]   wr_addr;

    col2img16_packer #(.DATA_OUT_WIDTH(8), .DEPTH(1024)) dut (
        .clk           (clk),
        .rst           (rst),
        .clr           (clr),
        .start         (start),
        .output_offset (output_offset),
        .lane_num      (lane_num),
        .data_in       (data_in),
        .data_vld_in   (data_vld_in),
        .data_last_in  (data_last_in),
        .in_rdy        (in_rdy),
        .wr_data       (wr_data),
        .wr_be         (wr_be),
        .wr_addr       (wr_addr),
        .wr_en         (wr_en),
        .done          (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int done_cnt = 0;
    int wr_at_done = 0;
    int stalls = 0;
    logic [9:0]  wa[$];
    logic [7:0]  wb[$];
    logic [63:0] wd[$];
    int          wc[$];
    logic [7:0]  eq[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (wr_en) begin
            wa.push_back(wr_addr);
            wb.push_back(wr_be);
            wd.push_back(wr_data);
            wc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            wr_at_done = wa.size();
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] model_byte(input logic [7:0] b);
`ifdef PACKER_RELU_EN
        return b[7] ? 8'h00 : b;
`else
        return b;
`endif
    endfunction

    function automatic logic [127:0] mkvec(input logic [7:0] base,
                                           input int n);
        logic [127:0] v;
        for (int i = 0; i < 16; i++)
            v[i*8 +: 8] = (i < n) ? base + 8'(i) : 8'h7E;
        return v;
    endfunction

    task automatic clear_logs();
        wa.delete(); wb.delete(); wd.delete(); wc.delete(); eq.delete();
        done_cnt = 0;
        wr_at_done = 0;
        stalls = 0;
    endtask

    task automatic do_start(input logic [31:0] off, input logic [4:0] ln);
        start = 1'b1;
        output_offset = off;
        lane_num = ln;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_vec(input logic [127:0] v, input logic last,
                            input int n);
        int t = 0;
        data_in = v;
        data_vld_in = 1'b1;
        data_last_in = last;
        while (!in_rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        stalls += t;
        if (!in_rdy)
            chk("rdy_timeout", 0, 1);
        for (int i = 0; i < n; i++)
            eq.push_back(model_byte(v[i*8 +: 8]));
        @(negedge clk);
        data_vld_in = 1'b0;
        data_last_in = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (done_cnt == 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_done"}, done_cnt, 1);
    endtask

    task automatic check_stream(input string tag, input logic [9:0] base);
        int nw = (eq.size() + 7) / 8;
        chk({tag, "_nwr"}, wa.size(), nw);
        chk({tag, "_wr_at_done"}, wr_at_done, nw);
        for (int j = 0; j < nw && j < wa.size(); j++) begin
            logic [63:0] d = '0;
            logic [7:0]  be = '0;
            for (int b = 0; b < 8; b++) begin
                if (8 * j + b < eq.size()) begin
                    d[b*8 +: 8] = eq[8*j+b];
                    be[b] = 1'b1;
                end
            end
            chk($sformatf("%s_addr%0d", tag, j), wa[j], 10'(base + 10'(j)));
            chk($sformatf("%s_be%0d", tag, j), wb[j], be);
            chk($sformatf("%s_data%0d", tag, j), wd[j], d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int nwr;
        rst = 1'b1; clr = 1'b0; start = 1'b0;
        output_offset = '0; lane_num = '0; data_in = '0;
        data_vld_in = 1'b0; data_last_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_be", wr_be, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_done", done, 0);
        chk("rst_in_rdy", in_rdy, 0);

        // 16 lanes, 3 vectors -> 6 full words at 0x10
        clear_logs();
        do_start(32'h10, 5'd16);
        for (int k = 0; k < 3; k++)
            send_vec(mkvec(8'(16 * k), 16), k == 2, 16);
        wait_done("t1");
        check_stream("t1", 10'h10);

        // 5 lanes, 15 bytes; a stray start mid-run must be ignored
        clear_logs();
        do_start(32'h40, 5'd5);
        send_vec(mkvec(8'h30, 5), 1'b0, 5);
        do_start(32'h300, 5'd16);
        send_vec(mkvec(8'h40, 5), 1'b0, 5);
        send_vec(mkvec(8'h50, 5), 1'b1, 5);
        wait_done("t2");
        check_stream("t2", 10'h40);
        if (wb.size() == 2) begin
            chk("t2_be_last", wb[1], 8'h7F);
            chk("t2_word1", wd[1], 64'h0054_5352_5150_4443);
        end else begin
            chk("t2_two_writes", wb.size(), 2);
        end

        // valid held high: in_rdy throttles, writes back-to-back
        clear_logs();
        do_start(32'h80, 5'd16);
        for (int k = 0; k < 6; k++)
            send_vec(mkvec(8'(16 * k), 16), k == 5, 16);
        wait_done("t3");
        check_stream("t3", 10'h80);
        chk("t3_stalls", stalls, 4);
        if (wc.size() == 12)
            chk("t3_burst", wc[11] - wc[0], 11);
        else
            chk("t3_burst_n", wc.size(), 12);

        // address wrap, lane_num=0 means 16
        clear_logs();
        do_start(32'd1023, 5'd0);
        send_vec(mkvec(8'h60, 16), 1'b1, 16);
        wait_done("t4");
        check_stream("t4", 10'd1023);

        // clr mid-tile discards everything
        clear_logs();
        do_start(32'h100, 5'd16);
        send_vec(mkvec(8'h00, 16), 1'b0, 16);
        send_vec(mkvec(8'h10, 16), 1'b0, 16);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        nwr = wa.size();
        repeat (10) @(negedge clk);
        chk("t5_no_wr", wa.size(), nwr);
        chk("t5_no_done", done_cnt, 0);
        chk("t5_in_rdy", in_rdy, 0);
        clear_logs();
        do_start(32'h200, 5'd16);
        send_vec(mkvec(8'h20, 16), 1'b1, 16);
        wait_done("t5");
        check_stream("t5", 10'h200);

        // sign handling of 80/7F/FF/01
        clear_logs();
        do_start(32'h20, 5'd4);
        send_vec({{12{8'h7E}}, 8'h01, 8'hFF, 8'h7F, 8'h80}, 1'b1, 4);
        wait_done("t6");
        check_stream("t6", 10'h20);
        if (wd.size() == 1) begin
`ifdef PACKER_RELU_EN
            chk("t6_relu", wd[0], 64'h0000_0000_0100_7F00);
`else
            chk("t6_relu", wd[0], 64'h0000_0000_01FF_7F80);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
